// File: rtl/suprloco_bus_dma_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | suprloco_bus_dma_if                                                  |
// | Shared Z80 bus handshake, source read port and destination write.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface suprloco_bus_dma_if;
   logic        o_BUSRQ_n;
   logic        i_BUSAK_n;
   logic        o_BUS_OE;
   logic [15:0] o_ADDR;
   logic        o_RD_n;
   logic        o_MREQ_n;
   logic [7:0]  i_DI;
   logic [7:0]  o_DST_ADDR;
   logic [7:0]  o_DST_DO;
   logic        o_DST_WE;

   modport master (
      output o_BUSRQ_n, o_BUS_OE, o_ADDR, o_RD_n, o_MREQ_n,
      output o_DST_ADDR, o_DST_DO, o_DST_WE,
      input  i_BUSAK_n, i_DI
   );

   modport slave (
      input  o_BUSRQ_n, o_BUS_OE, o_ADDR, o_RD_n, o_MREQ_n,
      input  o_DST_ADDR, o_DST_DO, o_DST_WE,
      output i_BUSAK_n, i_DI
   );
endinterface
`default_nettype wire

// File: rtl/suprloco_bus_dma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | suprloco_bus_dma                                                     |
// | Takes the Z80 bus and copies LEN bytes from work RAM to a byte RAM.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module suprloco_bus_dma #(
   parameter logic [15:0] SRC_BASE = 16'hF800,
   parameter logic [7:0]  DST_BASE = 8'h00,
   parameter int          LEN      = 256
) (
   input  wire logic           i_CLK,
   input  wire logic           i_RST_n,
   input  wire logic           i_CEN,
   input  wire logic           i_TRIG,
   suprloco_bus_dma_if.master  bus,
   output logic                o_BUSY,
   output logic                o_DONE,
   output logic                o_ABORT
);

   localparam logic [8:0] c_LAST = 9'(LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_READ    = 3'd2,
      S_WRITE   = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t      r_state;
   logic [8:0]  r_cnt;
   logic        r_pend;
   logic        r_busrq_n;
   logic        r_bus_oe;
   logic        r_rd_n;
   logic [7:0]  r_dst_do;
   logic        r_busy;
   logic        r_done;
   logic        r_abort;

   assign bus.o_BUSRQ_n  = r_busrq_n;
   assign bus.o_BUS_OE   = r_bus_oe;
   assign bus.o_ADDR     = SRC_BASE + {7'd0, r_cnt};
   assign bus.o_RD_n     = r_rd_n;
   assign bus.o_MREQ_n   = r_rd_n;
   assign bus.o_DST_ADDR = DST_BASE + r_cnt[7:0];
   assign bus.o_DST_DO   = r_dst_do;
   // A grant lost on the write tick must not produce a stray destination write.
   assign bus.o_DST_WE   = (r_state == S_WRITE) & i_CEN & ~bus.i_BUSAK_n & i_RST_n;
   assign o_BUSY         = r_busy;
   assign o_DONE         = r_done;
   assign o_ABORT        = r_abort;

   always_ff @(posedge i_CLK) begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      if (!i_RST_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_pend    <= 1'b0;
         r_busrq_n <= 1'b1;
         r_bus_oe  <= 1'b0;
         r_rd_n    <= 1'b1;
         r_dst_do  <= '0;
         r_busy    <= 1'b0;
      end else if (i_CEN) begin
         case (r_state)
            S_IDLE: begin
               if (i_TRIG || r_pend) begin
                  r_state   <= S_REQ;
                  r_pend    <= 1'b0;
                  r_busrq_n <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            S_REQ: begin
               if (i_TRIG) r_pend <= 1'b1;
               if (!bus.i_BUSAK_n) begin
                  r_state  <= S_READ;
                  r_bus_oe <= 1'b1;
                  r_rd_n   <= 1'b0;
               end
            end
            S_READ, S_WRITE: begin
               if (bus.i_BUSAK_n) begin
                  r_state   <= S_IDLE;
                  r_cnt     <= '0;
                  r_pend    <= 1'b0;
                  r_busrq_n <= 1'b1;
                  r_bus_oe  <= 1'b0;
                  r_rd_n    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_abort   <= 1'b1;
               end else begin
                  if (i_TRIG) r_pend <= 1'b1;
                  if (r_state == S_READ) begin
                     r_dst_do <= bus.i_DI;
                     r_rd_n   <= 1'b1;
                     r_state  <= S_WRITE;
                  end else if (r_cnt == c_LAST) begin
                     r_state   <= S_RELEASE;
                     r_busrq_n <= 1'b1;
                     r_bus_oe  <= 1'b0;
                     r_done    <= 1'b1;
                  end else begin
                     r_cnt   <= r_cnt + 9'd1;
                     r_rd_n  <= 1'b0;
                     r_state <= S_READ;
                  end
               end
            end
            S_RELEASE: begin
               if (i_TRIG) r_pend <= 1'b1;
               if (bus.i_BUSAK_n) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_suprloco_bus_dma.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_suprloco_bus_dma                                                  |
// | Five parameter sets share clock/enable/reset; writes are scoreboarded.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_suprloco_bus_dma;

   localparam int N = 5;
   localparam logic [15:0] P_SRC [N] = '{16'hF800, 16'hFFFE, 16'hA000, 16'h9000, 16'h8000};
   localparam logic [7:0]  P_DST [N] = '{8'h10, 8'hFE, 8'h40, 8'h20, 8'h00};
   localparam int          P_LEN [N] = '{4, 4, 8, 1, 256};

   typedef struct {
      int         inst;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic clk, rst_n, cen;
   logic [N-1:0] trig, busak_n;
   logic [N-1:0] busrq_n_w, bus_oe_w, rd_n_w, mreq_n_w, we_w, busy_w, done_w, abort_w;
   logic [15:0]  addr_w [N];
   logic [7:0]   dadr_w [N];
   logic [7:0]   ddo_w  [N];

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_we[N]    = '{default: 0};
   int   n_done[N]  = '{default: 0};
   int   n_abort[N] = '{default: 0};
   int   act  = 0;
   logic hold = 1'b0;

   function automatic logic [7:0] src_data(input logic [15:0] a);
      case (a)
         16'hF800: return 8'h11;
         16'hF801: return 8'h22;
         16'hF802: return 8'h33;
         16'hF803: return 8'h44;
         default:  return a[7:0] + a[15:8] + 8'h5A;
      endcase
   endfunction

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      suprloco_bus_dma_if bus();
      assign bus.i_BUSAK_n = busak_n[gi];
      assign bus.i_DI      = src_data(bus.o_ADDR);
      assign busrq_n_w[gi] = bus.o_BUSRQ_n;
      assign bus_oe_w[gi]  = bus.o_BUS_OE;
      assign rd_n_w[gi]    = bus.o_RD_n;
      assign mreq_n_w[gi]  = bus.o_MREQ_n;
      assign we_w[gi]      = bus.o_DST_WE;
      assign addr_w[gi]    = bus.o_ADDR;
      assign dadr_w[gi]    = bus.o_DST_ADDR;
      assign ddo_w[gi]     = bus.o_DST_DO;

      suprloco_bus_dma #(
         .SRC_BASE (P_SRC[gi]),
         .DST_BASE (P_DST[gi]),
         .LEN      (P_LEN[gi])
      ) u_dut (
         .i_CLK   (clk),
         .i_RST_n (rst_n),
         .i_CEN   (cen),
         .i_TRIG  (trig[gi]),
         .bus     (bus),
         .o_BUSY  (busy_w[gi]),
         .o_DONE  (done_w[gi]),
         .o_ABORT (abort_w[gi])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Step enable on every second clock.
   initial begin
      cen = 1'b0;
      forever begin
         @(posedge clk);
         #1 cen = ~cen;
      end
   end

   task automatic wait_cen();
      do @(posedge clk); while (cen !== 1'b1);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, want);
      end
   endtask

   // CPU model: grants three ticks after request, releases one tick after BUSRQ_n rises.
   initial begin
      int gwait;
      busak_n = '1;
      gwait   = 0;
      forever begin
         wait_cen();
         #1;
         if (hold) begin
            busak_n[act] = 1'b1;
         end else if (busrq_n_w[act] == 1'b0) begin
            if (busak_n[act]) begin
               gwait++;
               if (gwait >= 3) begin
                  busak_n[act] = 1'b0;
                  gwait = 0;
               end
            end
         end else begin
            gwait = 0;
            busak_n[act] = 1'b1;
         end
      end
   end

   // Monitor: compares every destination write against the scoreboard.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (we_w[i]) begin
            n_we[i]++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: inst %0d wrote %0h to %0h, required no write", i, ddo_w[i], dadr_w[i]);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (e.inst != i || e.addr !== dadr_w[i] || e.data !== ddo_w[i]) begin
                  errors++;
                  $display("FAIL write_data: inst %0d got %0h@%0h required inst %0d %0h@%0h",
                           i, ddo_w[i], dadr_w[i], e.inst, e.data, e.addr);
               end
            end
         end
         if (done_w[i]) begin
            n_done[i]++;
            checks++;
            if (busrq_n_w[i] !== 1'b1 || bus_oe_w[i] !== 1'b0) begin
               errors++;
               $display("FAIL done_release: inst %0d busrq_n=%b bus_oe=%b required 1 0", i, busrq_n_w[i], bus_oe_w[i]);
            end
         end
         if (abort_w[i]) n_abort[i]++;
         if (bus_oe_w[i]) begin
            checks++;
            if (mreq_n_w[i] !== rd_n_w[i]) begin
               errors++;
               $display("FAIL mreq_eq_rd: inst %0d mreq_n=%b rd_n=%b", i, mreq_n_w[i], rd_n_w[i]);
            end
         end
      end
   end

   task automatic push(input int i, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.inst = i;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic pulse_trig(input int i);
      trig[i] = 1'b1;
      wait_cen();
      trig[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i, input string nm);
      int t;
      t = 0;
      while (busy_w[i] && t < 3000) begin
         wait_cen();
         t++;
      end
      chk({nm, "_timeout"}, 32'(t < 3000), 32'd1);
   endtask

   task automatic chk_reset(input int i, input string nm);
      chk({nm, "_busrq_n"}, 32'(busrq_n_w[i]), 32'd1);
      chk({nm, "_bus_oe"},  32'(bus_oe_w[i]),  32'd0);
      chk({nm, "_rd_n"},    32'(rd_n_w[i]),    32'd1);
      chk({nm, "_mreq_n"},  32'(mreq_n_w[i]),  32'd1);
      chk({nm, "_dst_we"},  32'(we_w[i]),      32'd0);
      chk({nm, "_dst_do"},  32'(ddo_w[i]),     32'd0);
      chk({nm, "_busy"},    32'(busy_w[i]),    32'd0);
      chk({nm, "_done"},    32'(done_w[i]),    32'd0);
      chk({nm, "_abort"},   32'(abort_w[i]),   32'd0);
   endtask

   initial begin
      int w0, d0, a0, t;
      trig  = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) chk_reset(i, "por");
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // Nominal copy F800..F803 -> 10..13
      act = 0;
      w0 = n_we[0]; d0 = n_done[0]; a0 = n_abort[0];
      push(0, 8'h10, 8'h11); push(0, 8'h11, 8'h22);
      push(0, 8'h12, 8'h33); push(0, 8'h13, 8'h44);
      pulse_trig(0);
      chk("nominal_busrq_low", 32'(busrq_n_w[0]), 32'd0);
      wait_idle(0, "nominal");
      chk("nominal_writes", 32'(n_we[0] - w0), 32'd4);
      chk("nominal_done", 32'(n_done[0] - d0), 32'd1);
      chk("nominal_abort", 32'(n_abort[0] - a0), 32'd0);

      // Address wrap on both sides
      act = 1;
      w0 = n_we[1]; d0 = n_done[1];
      push(1, 8'hFE, 8'h57); push(1, 8'hFF, 8'h58);
      push(1, 8'h00, 8'h5A); push(1, 8'h01, 8'h5B);
      pulse_trig(1);
      wait_idle(1, "wrap");
      chk("wrap_writes", 32'(n_we[1] - w0), 32'd4);
      chk("wrap_done", 32'(n_done[1] - d0), 32'd1);

      // Three triggers during a busy transfer yield exactly one more
      act = 0;
      w0 = n_we[0]; d0 = n_done[0];
      for (int k = 0; k < 2; k++) begin
         push(0, 8'h10, 8'h11); push(0, 8'h11, 8'h22);
         push(0, 8'h12, 8'h33); push(0, 8'h13, 8'h44);
      end
      pulse_trig(0);
      for (int k = 0; k < 3; k++) begin
         repeat (2) wait_cen();
         pulse_trig(0);
      end
      wait_idle(0, "overlap_first");
      wait_cen();
      chk("overlap_rereq_busrq_n", 32'(busrq_n_w[0]), 32'd0);
      chk("overlap_rereq_busy", 32'(busy_w[0]), 32'd1);
      wait_idle(0, "overlap_second");
      repeat (6) wait_cen();
      chk("overlap_writes", 32'(n_we[0] - w0), 32'd8);
      chk("overlap_done", 32'(n_done[0] - d0), 32'd2);
      chk("overlap_idle_busrq_n", 32'(busrq_n_w[0]), 32'd1);

      // Grant lost during the READ of byte 2
      act = 2;
      w0 = n_we[2]; d0 = n_done[2]; a0 = n_abort[2];
      push(2, 8'h40, 8'hFA); push(2, 8'h41, 8'hFB);
      pulse_trig(2);
      t = 0;
      while (!(dadr_w[2] == 8'h42 && rd_n_w[2] == 1'b0) && t < 200) begin
         wait_cen();
         t++;
      end
      chk("grantloss_reach_byte2", 32'(t < 200), 32'd1);
      hold = 1'b1;
      wait_idle(2, "grantloss");
      hold = 1'b0;
      wait_cen();
      chk("grantloss_abort", 32'(n_abort[2] - a0), 32'd1);
      chk("grantloss_done", 32'(n_done[2] - d0), 32'd0);
      chk("grantloss_writes", 32'(n_we[2] - w0), 32'd2);
      chk("grantloss_busy", 32'(busy_w[2]), 32'd0);
      chk("grantloss_bus_oe", 32'(bus_oe_w[2]), 32'd0);

      // LEN=1
      act = 3;
      w0 = n_we[3]; d0 = n_done[3];
      push(3, 8'h20, 8'hEA);
      pulse_trig(3);
      wait_idle(3, "len1");
      chk("len1_writes", 32'(n_we[3] - w0), 32'd1);
      chk("len1_done", 32'(n_done[3] - d0), 32'd1);

      // LEN=256 from 8000 -> data is low address byte + DA
      act = 4;
      w0 = n_we[4]; d0 = n_done[4];
      for (int k = 0; k < 256; k++) push(4, 8'(k), 8'(k + 8'hDA));
      pulse_trig(4);
      wait_idle(4, "len256");
      chk("len256_writes", 32'(n_we[4] - w0), 32'd256);
      chk("len256_done", 32'(n_done[4] - d0), 32'd1);

      // Reset held for 3 clocks in the middle of the first READ
      act = 0;
      repeat (4) wait_cen();
      pulse_trig(0);
      t = 0;
      while (rd_n_w[0] !== 1'b0 && t < 50) begin
         wait_cen();
         t++;
      end
      chk("midreset_reach_read", 32'(t < 50), 32'd1);
      chk("midreset_read_bus_oe", 32'(bus_oe_w[0]), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      chk_reset(0, "midreset");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (8) wait_cen();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
